// File: rtl/cla12_pkg.sv
// cla12_pkg
// Shared definitions for the multi-cycle wide adder built on one cla12 slice.
//   SLICE_W   : width of the shared carry-lookahead adder slice
//   state_e   : sequencer states (IDLE waits for start, RUN walks the slices)
//   idx_width : width of the slice index counter, at least one bit
package cla12_pkg;

  localparam int SLICE_W = 12;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // A single-slice configuration still needs a 1-bit index register.
  function automatic int idx_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/cla12_wide_seq_if.sv
// cla12_wide_seq_if
// Host-side handshake and data bus of the sequenced wide adder.
//   start          : host request, honoured only while busy is low
//   a, b, cin      : operands and carry-in, captured when start is accepted
//   busy           : an operation is in flight
//   done           : one-cycle pulse, results valid from this cycle on
//   sum, cout, ovf : W-bit result, unsigned carry-out, signed overflow
// Modports: master = host side, slave = adder side.
interface cla12_wide_seq_if #(
  parameter int SLICES = 4
);
  import cla12_pkg::*;

  localparam int W = SLICE_W * SLICES;

  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf
  );

endinterface

// File: rtl/cla12.sv
// cla12
// Purely combinational 12-bit carry-lookahead adder.
// It is built from three 4-bit lookahead groups joined by a second-level
// lookahead across the groups.
//   a, b : 12-bit addends
//   cin  : carry into bit 0
//   sum  : a + b + cin, low 12 bits
//   cout : carry out of bit 11
module cla12
  import cla12_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W-1:0] c;
  logic [2:0]         gp;
  logic [2:0]         gg;
  logic [2:0]         gc;

  assign p = a ^ b;
  assign g = a & b;

  // Group propagate/generate for each 4-bit group.
  always_comb begin
    gp = '0;
    gg = '0;
    for (int k = 0; k < 3; k++) begin
      gp[k] = p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k];
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
    end
  end

  // Second level: every group carry comes straight from cin, with no ripple between groups.
  always_comb begin
    gc[0] = cin;
    gc[1] = gg[0] | (gp[0] & cin);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & cin);
    cout  = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & cin);
  end

  // First level: bit carries inside each group, expanded from the group carry.
  always_comb begin
    c = '0;
    for (int k = 0; k < 3; k++) begin
      c[4*k]   = gc[k];
      c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1])
               | (p[4*k+2] & p[4*k+1] & g[4*k])
               | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
    end
  end

  assign sum = p ^ c;

endmodule

// File: rtl/cla12_wide_seq.sv
// cla12_wide_seq
// Multi-cycle W-bit adder, with W = 12*SLICES.
// One shared cla12 is stepped over the operand slices, least significant
// slice first. The carry between slices is held in a register.
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : slave side of cla12_wide_seq_if (start/busy/done, a/b/cin, sum/cout/ovf)
// done arrives SLICES cycles after the accept edge. The result stays on
// the outputs until the next operation starts overwriting it.
module cla12_wide_seq
  import cla12_pkg::*;
#(
  parameter int SLICES = 4
) (
  input  logic               clk,
  input  logic               rst,
  cla12_wide_seq_if.slave    bus
);

  localparam int W     = SLICE_W * SLICES;
  localparam int IDX_W = idx_width(SLICES);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [W-1:0]       a_q, a_d;
  logic [W-1:0]       b_q, b_d;
  logic               carry_q, carry_d;
  logic [W-1:0]       sum_q, sum_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SLICE_W-1:0] slice_a;
  logic [SLICE_W-1:0] slice_b;
  logic [SLICE_W-1:0] cla_sum;
  logic               cla_cout;
  logic               last_slice;

  assign slice_a    = a_q[SLICE_W*idx_q +: SLICE_W];
  assign slice_b    = b_q[SLICE_W*idx_q +: SLICE_W];
  assign last_slice = (idx_q == IDX_W'(SLICES - 1));

  cla12 u_cla12 (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry_q),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Sequencer next state. sum is not cleared on accept, so earlier result
  // slices stay visible until RUN overwrites them.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[SLICE_W*idx_q +: SLICE_W] = cla_sum;
        carry_d = cla_cout;
        idx_d   = idx_q + IDX_W'(1);
        if (last_slice) begin
          // The top slice holds the sign bits, so overflow is decided here.
          cout_d  = cla_cout;
          ovf_d   = (a_q[W-1] == b_q[W-1]) && (cla_sum[SLICE_W-1] != a_q[W-1]);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          idx_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_cla12_wide_seq.sv
// tb_cla12_wide_seq
// Directed and random operations on the 48-bit (SLICES=4) sequenced adder.
// Expected results come from plain 49-bit arithmetic. Expected done timing
// comes from the handshake rules.
module tb_cla12_wide_seq;

  localparam int SLICES = 4;
  localparam int W      = 12 * SLICES;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  cla12_wide_seq_if #(.SLICES(SLICES)) bus ();

  cla12_wide_seq #(.SLICES(SLICES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result packed as {ovf, cout, sum}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c);
    logic [W:0]   full;
    logic [W-1:0] s;
    logic         v;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    s    = full[W-1:0];
    v    = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
    return {v, full[W], s};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkResult(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c);
    logic [W+1:0] exp;
    exp = model(a, b, c);
    checkOutput({tag, "_sum"},  64'(bus.sum),  64'(exp[W-1:0]));
    checkOutput({tag, "_cout"}, 64'(bus.cout), 64'(exp[W]));
    checkOutput({tag, "_ovf"},  64'(bus.ovf),  64'(exp[W+1]));
  endtask

  // Count edges until done is seen. The count includes edges the caller has
  // already consumed since the accept edge. A missing done stops at 12 and
  // shows up as a latency mismatch.
  task automatic waitDone(input string tag, input int expected, input int elapsed);
    int  n;
    bit  seen;
    n    = elapsed;
    seen = 1'b0;
    while (!seen && n < 12) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.done === 1'b1) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, 64'(n), 64'(expected));
  endtask

  task automatic applyStimulus(input logic [W-1:0] opA, input logic [W-1:0] opB,
                               input logic c);
    @(negedge clk);
    bus.a     = opA;
    bus.b     = opB;
    bus.cin   = c;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Operands are registered, so changing them after accept must not matter.
    bus.a     = W'({$urandom(), $urandom()});
    bus.b     = W'({$urandom(), $urandom()});
    bus.cin   = 1'($urandom());
  endtask

  task automatic runOp(input string tag, input logic [W-1:0] opA, input logic [W-1:0] opB,
                       input logic c);
    applyStimulus(opA, opB, c);
    checkOutput({tag, "_busy"}, 64'(bus.busy), 64'(1));
    waitDone(tag, SLICES, 0);
    checkOutput({tag, "_busy_at_done"}, 64'(bus.busy), 64'(0));
    checkResult(tag, opA, opB, c);
    @(posedge clk);
    #1;
    checkOutput({tag, "_done_pulse"}, 64'(bus.done), 64'(0));
    checkResult({tag, "_hold"}, opA, opB, c);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic [W-1:0] b2a;
    logic [W-1:0] b2b;
    int           doneCount;

    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(bus.busy), 64'(0));
    checkOutput("reset_done", 64'(bus.done), 64'(0));
    checkOutput("reset_sum",  64'(bus.sum),  64'(0));
    checkOutput("reset_cout", 64'(bus.cout), 64'(0));
    checkOutput("reset_ovf",  64'(bus.ovf),  64'(0));
    rst = 1'b0;

    $display("[TB] directed operations");
    runOp("zero",       48'h0, 48'h0, 1'b0);
    runOp("small1",     48'd15, 48'd1795, 1'b1);
    runOp("small2",     48'd11, 48'd3311, 1'b0);
    runOp("cross",      48'h000000000FFF, 48'h1, 1'b0);
    runOp("wrap",       48'hFFFFFFFFFFFF, 48'h0, 1'b1);
    runOp("sovf_pos",   48'h7FFFFFFFFFFF, 48'h1, 1'b0);
    runOp("sovf_neg",   48'h800000000000, 48'h800000000000, 1'b0);
    runOp("cin_only",   48'h0, 48'h0, 1'b1);

    $display("[TB] start ignored while busy");
    ra = 48'h123456789ABC;
    rb = 48'h0FEDCBA98765;
    applyStimulus(ra, rb, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = W'({$urandom(), $urandom()});
      bus.b     = W'({$urandom(), $urandom()});
      @(posedge clk);
      #1;
      checkOutput("ignore_no_early_done", 64'(bus.done), 64'(0));
    end
    @(negedge clk);
    bus.start = 1'b0;
    waitDone("ignore", SLICES, 3);
    checkResult("ignore", ra, rb, 1'b1);

    $display("[TB] back-to-back with start held");
    ra  = 48'hFFF000FFF000;
    rb  = 48'h001FFF001FFF;
    b2a = 48'hAAAAAAAAAAAA;
    b2b = 48'h555555555555;
    @(negedge clk);
    bus.a     = ra;
    bus.b     = rb;
    bus.cin   = 1'b0;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.a     = 48'h0;
    bus.b     = 48'h0;
    waitDone("b2b_first", SLICES, 0);
    checkResult("b2b_first", ra, rb, 1'b0);
    bus.a     = b2a;
    bus.b     = b2b;
    bus.cin   = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    waitDone("b2b_second", SLICES + 1, 1);
    checkResult("b2b_second", b2a, b2b, 1'b1);

    $display("[TB] reset in the middle of an operation");
    applyStimulus(48'h111111111111, 48'h222222222222, 1'b0);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    #1;
    rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(bus.busy), 64'(0));
    checkOutput("abort_done", 64'(bus.done), 64'(0));
    checkOutput("abort_sum",  64'(bus.sum),  64'(0));
    checkOutput("abort_cout", 64'(bus.cout), 64'(0));
    checkOutput("abort_ovf",  64'(bus.ovf),  64'(0));
    @(negedge clk);
    rst = 1'b0;
    doneCount = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1) doneCount++;
    end
    checkOutput("abort_no_done", 64'(doneCount), 64'(0));
    runOp("after_abort", 48'h00000ABCDEF0, 48'h000001234567, 1'b1);

    $display("[TB] random operations");
    for (int i = 0; i < 24; i++) begin
      ra = W'({$urandom(), $urandom()});
      case ($urandom_range(0, 3))
        0: rb = W'({$urandom(), $urandom()});
        1: rb = ~ra;
        2: rb = W'(1) << $urandom_range(0, W - 1);
        default: rb = ra;
      endcase
      rc = 1'($urandom());
      runOp("random", ra, rb, rc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
